program_loader: RTL and testbench
=================================

# program_loader

Boot-time program loader that sits directly upstream of program memory and feeds its load port. It accepts a byte stream over a valid/ready handshake, assembles each pair of bytes into one 12-bit instruction, and writes the instructions to consecutive program-memory addresses starting at 0. After the last write it raises `load_done`, which releases the processor from its LOAD stage.

## Interface
Parameters:
- `ADDR_W`, 8: program-memory address width.
- `INST_W`, 12: instruction width; the upper byte carries `INST_W-8` significant bits.
- `PROG_LEN`, 18: number of instructions per load; legal range 1..2^ADDR_W.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  single-cycle request to begin a load.
- `byte_in`  in  8  stream data.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `load_e`  out  1  program-memory write enable; connects to PMem `LoadE`.
- `load_addr`  out  ADDR_W  write address.
- `load_inst`  out  INST_W  write data.
- `load_done`  out  1  load completed; held high.
- `busy`  out  1  high in HI, LO and WRITE.
- `err`  out  1  format error; held high.
- `checksum`  out  8  running modulo-256 sum of all accepted bytes in the current load.

## Operation
- States: IDLE, HI, LO, WRITE, DONE, ERR.
- A byte is accepted when `byte_valid && byte_ready`.
- IDLE:
  - `byte_ready`=0.
  - On `start`: clear `load_addr`, `checksum`, `load_done` and `err`, then go to HI.
- HI:
  - `byte_ready`=1.
  - On accept, if `byte_in[7:4]!=0`: go to ERR. The byte is still added to `checksum`.
  - On accept otherwise: latch `byte_in[3:0]` as the high nibble and go to LO.
- LO:
  - `byte_ready`=1.
  - On accept: set `load_inst <= {hi_nibble, byte_in}`, add the byte to `checksum`, and go to WRITE.
- WRITE:
  - `load_e`=1 for exactly this one cycle; `byte_ready`=0.
  - If `load_addr==PROG_LEN-1`: go to DONE and leave `load_addr` unchanged.
  - Otherwise: increment `load_addr` on exit and go to HI.
- DONE:
  - `load_done`=1.
  - `start` restarts the load exactly as from IDLE.
- ERR:
  - `err`=1; `load_addr` and `checksum` freeze.
  - `start` restarts the load exactly as from IDLE.
- `start` is ignored in HI, LO and WRITE.
- Stalls: `byte_valid` low in HI or LO holds the state indefinitely; there is no timeout.
- Width rules:
  - `load_addr` increments without wrap; `PROG_LEN` bounds it.
  - `checksum` wraps modulo 256.

## Timing
- Reset values: state IDLE, `byte_ready`=0, `load_e`=0, `load_addr`=0, `load_inst`=0, `load_done`=0, `busy`=0, `err`=0, `checksum`=0.
- Output sources:
  - `byte_ready`, `load_e` and `busy` are decoded from the state register only, never from inputs.
  - `load_addr`, `load_inst` and `checksum` are registered.
- Latency:
  - `start` at cycle 0 puts the loader in HI at cycle 1.
  - A low-byte accept at cycle M gives `load_e` high at cycle M+1, with `load_addr` and `load_inst` stable. PMem captures the write at the end of M+1.
- Throughput: with `byte_valid` held high, one instruction takes 3 cycles. A full load takes 3·`PROG_LEN` cycles after HI is entered.
- `load_done` rises in the cycle after the final WRITE.
- Reset mid-operation forces IDLE immediately and asynchronously. Any write in progress is abandoned, and `load_e` drops without waiting for a clock edge.

## Structure
- Shared package `loader_pkg`:
  - state enum `loader_state_t`;
  - constants `LOADER_HI_MASK` (8'hF0) and `DEFAULT_PROG_LEN` (18).
- Single module; no sub-module is warranted.
- Top-level integration: the loader replaces the file-based load path.
  - `load_done` drives the processor's LOAD→FETCH transition.
  - `load_e` drives PMem `LoadE`.

## Test plan
- Reset, then `start`, then 36 back-to-back bytes encoding 12'h000..12'h011 → 18 `load_e` pulses at addresses 0..17 with the matching data, 3 cycles apart. `load_done`=1 after the last write. `checksum` equals the sum of the 36 bytes mod 256.
- Same stream with `byte_valid` deasserted for 5 cycles between the high and low byte of instruction 4 → state holds LO; write to address 4 = 12'h004, delayed by exactly 5 cycles.
- High byte 8'h1A at instruction 2 → `err`=1, no further `load_e`, `load_addr`=2. A following `start` plus a valid stream completes a clean load with `err`=0.
- `rst` asserted mid-WRITE (instruction 7) → `load_e`, `busy` and `load_addr` clear asynchronously; the state is IDLE; `byte_ready`=0 until the next `start`.
- `start` pulsed during LO → ignored, no address reset. `start` in DONE → `load_done` clears and the reload begins at address 0.
- `PROG_LEN`=1: two bytes 8'h0F, 8'hFF → one write of 12'hFFF at address 0, `load_done`=1, `checksum`=8'h0E.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } loader_state_t;

  // Bits of the high byte that must be zero for a well-formed instruction.
  localparam logic [7:0] LOADER_HI_MASK = 8'hF0;

  localparam int unsigned DEFAULT_PROG_LEN = 18;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory load port of the loader.
interface program_loader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned INST_W = 12
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              load_e;
  logic [ADDR_W-1:0] load_addr;
  logic [INST_W-1:0] load_inst;

  // Host side: drives the byte stream and observes the load port.
  modport master (
    output byte_in, byte_valid,
    input  byte_ready, load_e, load_addr, load_inst
  );

  // Loader side: consumes the byte stream and drives the load port.
  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, load_e, load_addr, load_inst
  );
endinterface

// File: rtl/program_loader.sv
// Assembles byte pairs into instructions and writes them to program memory
// at consecutive addresses from 0; raises load_done after the last write.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INST_W   = 12,
  parameter int unsigned PROG_LEN = DEFAULT_PROG_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  program_loader_if.slave      bus,
  output logic                 load_done,
  output logic                 busy,
  output logic                 err,
  output logic [7:0]           checksum
);

  localparam int unsigned HI_W = INST_W - 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);

  loader_state_t     state;
  logic [ADDR_W-1:0] addr_q;
  logic [INST_W-1:0] inst_q;
  logic [HI_W-1:0]   hi_q;
  logic [7:0]        sum_q;
  logic              hi_bad;

  // A high byte with any masked bit set is a format error.
  assign hi_bad = |(bus.byte_in & LOADER_HI_MASK);

  // State machine plus address, instruction and checksum registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      inst_q <= '0;
      hi_q   <= '0;
      sum_q  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            addr_q <= '0;
            sum_q  <= '0;
            state  <= ST_HI;
          end
        end
        ST_HI: begin
          if (bus.byte_valid) begin
            sum_q <= sum_q + bus.byte_in;
            if (hi_bad) begin
              state <= ST_ERR;
            end else begin
              hi_q  <= bus.byte_in[HI_W-1:0];
              state <= ST_LO;
            end
          end
        end
        ST_LO: begin
          if (bus.byte_valid) begin
            inst_q <= {hi_q, bus.byte_in};
            sum_q  <= sum_q + bus.byte_in;
            state  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (addr_q == LAST_ADDR) begin
            state <= ST_DONE;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
            state  <= ST_HI;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake and status flags decode the state register only, so reset
  // clears them without waiting for a clock edge.
  assign bus.byte_ready = (state == ST_HI) || (state == ST_LO);
  assign bus.load_e     = (state == ST_WRITE);
  assign busy           = (state == ST_HI) || (state == ST_LO) || (state == ST_WRITE);
  assign load_done      = (state == ST_DONE);
  assign err            = (state == ST_ERR);

  assign bus.load_addr  = addr_q;
  assign bus.load_inst  = inst_q;
  assign checksum       = sum_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as bytes
// are driven and checked when load_e pulses.
module tb_program_loader;
  import loader_pkg::*;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned INST_W = 12;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1;
  logic       load_done, busy, err;
  logic       load_done1, busy1, err1;
  logic [7:0] checksum, checksum1;

  int         tests = 0;
  int         fails = 0;
  int         cycle = 0;
  wr_t        exp_q[$];
  int         wr_cyc[$];
  wr_t        mon_e;
  bit         mon_en = 1'b0;
  logic [7:0] exp_sum = 8'h00;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  program_loader_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();
  program_loader_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus1 ();

  program_loader #(.ADDR_W(ADDR_W), .INST_W(INST_W), .PROG_LEN(18)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .load_done(load_done), .busy(busy), .err(err), .checksum(checksum)
  );

  program_loader #(.ADDR_W(ADDR_W), .INST_W(INST_W), .PROG_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bus(bus1),
    .load_done(load_done1), .busy(busy1), .err(err1), .checksum(checksum1)
  );

  // Write monitor: every load_e pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && bus.load_e === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: addr=%0d inst=%h, required no write",
                 bus.load_addr, bus.load_inst);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.load_addr, bus.load_inst} !== mon_e) begin
          fails++;
          $display("FAIL write: addr=%0d inst=%h, required addr=%0d inst=%h",
                   bus.load_addr, bus.load_inst, mon_e.addr, mon_e.inst);
        end
      end
      wr_cyc.push_back(cycle);
    end
  end

  task automatic pulse_start();
    start   = 1'b1;
    exp_sum = 8'h00;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = (bus.byte_ready === 1'b1);
      @(posedge clk); #1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send_timeout: byte %h not accepted in 20 cycles, required accept", b);
    end else begin
      exp_sum = exp_sum + b;
    end
  endtask

  task automatic send_inst(input int addr, input logic [11:0] inst, input bit push);
    if (push) exp_q.push_back(wr_t'{addr: ADDR_W'(addr), inst: inst});
    send_byte({4'h0, inst[11:8]});
    send_byte(inst[7:0]);
  endtask

  task automatic load_range(input int from, input int to,
                            input logic [11:0] base, input logic [11:0] step);
    for (int i = from; i <= to; i++) send_inst(i, base + 12'(i) * step, 1'b1);
  endtask

  // Called in the WRITE cycle of the final instruction.
  task automatic finish_load();
    bus.byte_valid = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (load_done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_flags: done=%b err=%b busy=%b, required 1 0 0", load_done, err, busy);
    end
    tests++;
    if (bus.load_addr !== 8'd17) begin
      fails++;
      $display("FAIL done_addr: %0d, required 17", bus.load_addr);
    end
    tests++;
    if (checksum !== exp_sum) begin
      fails++;
      $display("FAIL checksum: %h, required %h", checksum, exp_sum);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_writes: %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    bus.byte_in = 8'h00;  bus.byte_valid = 1'b0;
    bus1.byte_in = 8'h00; bus1.byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (dut.state !== ST_IDLE || bus.byte_ready !== 1'b0 || bus.load_e !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: state=%0d ready=%b load_e=%b busy=%b, required IDLE 0 0 0",
               dut.state, bus.byte_ready, bus.load_e, busy);
    end
    tests++;
    if (bus.load_addr !== 8'd0 || bus.load_inst !== 12'h000 || checksum !== 8'h00) begin
      fails++;
      $display("FAIL reset_data: addr=%h inst=%h sum=%h, required 0 0 0",
               bus.load_addr, bus.load_inst, checksum);
    end
    tests++;
    if (load_done !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: done=%b err=%b, required 0 0", load_done, err);
    end
  endtask

  task automatic test_full_load();
    exp_q.delete(); wr_cyc.delete(); mon_en = 1'b1;
    pulse_start();
    tests++;
    if (dut.state !== ST_HI || busy !== 1'b1) begin
      fails++;
      $display("FAIL start_to_hi: state=%0d busy=%b, required HI 1", dut.state, busy);
    end
    load_range(0, 17, 12'h000, 12'h001);
    finish_load();
    tests++;
    if (exp_sum !== 8'h99 || wr_cyc.size() != 18) begin
      fails++;
      $display("FAIL full_count: model_sum=%h writes=%0d, required 99 18", exp_sum, wr_cyc.size());
    end
    for (int i = 1; i < wr_cyc.size(); i++) begin
      tests++;
      if (wr_cyc[i] - wr_cyc[i-1] != 3) begin
        fails++;
        $display("FAIL full_gap: write %0d gap %0d, required 3", i, wr_cyc[i] - wr_cyc[i-1]);
      end
    end
  endtask

  task automatic test_stall();
    wr_cyc.delete();
    pulse_start();
    load_range(0, 3, 12'h000, 12'h001);
    exp_q.push_back(wr_t'{addr: 8'd4, inst: 12'h004});
    send_byte(8'h00);
    bus.byte_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++;
      if (dut.state !== ST_LO || bus.byte_ready !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold: state=%0d ready=%b, required LO 1", dut.state, bus.byte_ready);
      end
      @(posedge clk); #1;
    end
    send_byte(8'h04);
    load_range(5, 17, 12'h000, 12'h001);
    finish_load();
    for (int i = 1; i < wr_cyc.size(); i++) begin
      tests++;
      if (wr_cyc[i] - wr_cyc[i-1] != ((i == 4) ? 8 : 3)) begin
        fails++;
        $display("FAIL stall_gap: write %0d gap %0d, required %0d",
                 i, wr_cyc[i] - wr_cyc[i-1], (i == 4) ? 8 : 3);
      end
    end
  endtask

  task automatic test_error();
    pulse_start();
    load_range(0, 1, 12'h000, 12'h001);
    send_byte(8'h1A);
    bus.byte_in = 8'h05;
    repeat (6) @(posedge clk);
    #1;
    tests++;
    if (err !== 1'b1 || busy !== 1'b0 || bus.byte_ready !== 1'b0 || load_done !== 1'b0) begin
      fails++;
      $display("FAIL err_flags: err=%b busy=%b ready=%b done=%b, required 1 0 0 0",
               err, busy, bus.byte_ready, load_done);
    end
    tests++;
    if (bus.load_addr !== 8'd2 || checksum !== exp_sum || exp_sum !== 8'h1B) begin
      fails++;
      $display("FAIL err_freeze: addr=%0d sum=%h, required 2 %h", bus.load_addr, checksum, exp_sum);
    end
    bus.byte_valid = 1'b0;
    pulse_start();
    tests++;
    if (err !== 1'b0 || dut.state !== ST_HI) begin
      fails++;
      $display("FAIL err_restart: err=%b state=%0d, required 0 HI", err, dut.state);
    end
    load_range(0, 17, 12'h3C5, 12'h0B7);
    finish_load();
  endtask

  task automatic test_reset_mid_write();
    pulse_start();
    load_range(0, 6, 12'h100, 12'h011);
    send_inst(7, 12'h177, 1'b0);
    tests++;
    if (bus.load_e !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_write: load_e=%b, required 1", bus.load_e);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if (bus.load_e !== 1'b0 || busy !== 1'b0 || bus.load_addr !== 8'd0 || dut.state !== ST_IDLE) begin
      fails++;
      $display("FAIL async_reset: load_e=%b busy=%b addr=%0d state=%0d, required 0 0 0 IDLE",
               bus.load_e, busy, bus.load_addr, dut.state);
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.byte_ready !== 1'b0 || dut.state !== ST_IDLE || checksum !== 8'h00) begin
      fails++;
      $display("FAIL post_reset_idle: ready=%b state=%0d sum=%h, required 0 IDLE 00",
               bus.byte_ready, dut.state, checksum);
    end
    bus.byte_valid = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL reset_writes: %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_start_ignored();
    pulse_start();
    load_range(0, 2, 12'h000, 12'h001);
    exp_q.push_back(wr_t'{addr: 8'd3, inst: 12'h003});
    send_byte(8'h00);
    bus.byte_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (dut.state !== ST_LO || bus.load_addr !== 8'd3 || checksum !== exp_sum) begin
      fails++;
      $display("FAIL start_in_lo: state=%0d addr=%0d sum=%h, required LO 3 %h",
               dut.state, bus.load_addr, checksum, exp_sum);
    end
    send_byte(8'h03);
    load_range(4, 17, 12'h000, 12'h001);
    finish_load();
    pulse_start();
    tests++;
    if (load_done !== 1'b0 || dut.state !== ST_HI || bus.load_addr !== 8'd0 || checksum !== 8'h00) begin
      fails++;
      $display("FAIL start_in_done: done=%b state=%0d addr=%0d sum=%h, required 0 HI 0 00",
               load_done, dut.state, bus.load_addr, checksum);
    end
    load_range(0, 17, 12'h0F0, 12'h0F1);
    finish_load();
  endtask

  task automatic test_prog_len1();
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    bus1.byte_in = 8'h0F; bus1.byte_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (bus1.byte_ready !== 1'b1) begin
      fails++;
      $display("FAIL len1_ready: %b, required 1", bus1.byte_ready);
    end
    @(posedge clk); #1;
    bus1.byte_in = 8'hFF;
    @(posedge clk); #1;
    bus1.byte_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus1.load_e !== 1'b1 || bus1.load_addr !== 8'd0 || bus1.load_inst !== 12'hFFF) begin
      fails++;
      $display("FAIL len1_write: load_e=%b addr=%0d inst=%h, required 1 0 fff",
               bus1.load_e, bus1.load_addr, bus1.load_inst);
    end
    @(posedge clk); #1;
    tests++;
    if (load_done1 !== 1'b1 || checksum1 !== 8'h0E || bus1.load_addr !== 8'd0 || busy1 !== 1'b0 || err1 !== 1'b0) begin
      fails++;
      $display("FAIL len1_done: done=%b sum=%h addr=%0d busy=%b err=%b, required 1 0e 0 0 0",
               load_done1, checksum1, bus1.load_addr, busy1, err1);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_stall();
    test_error();
    test_reset_mid_write();
    test_start_ignored();
    test_prog_len1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
